// File: rtl/push_debounce.sv
// push_debounce: four-channel synchronized push-button debouncer with press/release pulses and sticky press flags
module push_debounce #(
  parameter int DB_TICKS = 500000,
  parameter int CNT_W = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] PUSH,
  input  logic [3:0] EVENT_CLR,
  output logic [3:0] KEY_LEVEL,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [3:0] KEY_EVENT
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_TICKS - 1);
  logic [3:0] s1, s2, stable, press, rel, ev, sync, flip;
  logic [CNT_W-1:0] cnt [4];
  assign sync = ~s2;
  for (genvar i = 0; i < 4; i++) begin : g_ch
    assign flip[i] = (sync[i] != stable[i]) && (cnt[i] == LAST);
    always_ff @(posedge CLK)
      cnt[i] <= (RST || sync[i] == stable[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= '1;
      s2 <= '1;
      stable <= '0;
      press <= '0;
      rel <= '0;
      ev <= '0;
    end else begin
      s1 <= PUSH;
      s2 <= s1;
      stable <= stable ^ flip;
      press <= flip & ~stable;
      rel <= flip & stable;
      ev <= (ev & ~EVENT_CLR) | press;
    end
  end
  // press is folded in so a clear landing in the press cycle cannot win
  assign KEY_EVENT = ev | press;
  assign KEY_LEVEL = stable;
  assign KEY_PRESS = press;
  assign KEY_RELEASE = rel;
endmodule

// File: tb/tb_push_debounce.sv
// tb_push_debounce: directed scoreboard bench for push_debounce with DB_TICKS=4
module tb_push_debounce;
  logic CLK = 0, RST = 1;
  logic [3:0] PUSH = 4'hF, EVENT_CLR = 4'h0;
  logic [3:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_EVENT;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {int c; logic [3:0] p; logic [3:0] r;} exp_t;
  exp_t q[$];

  push_debounce #(.DB_TICKS(4), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .EVENT_CLR(EVENT_CLR),
    .KEY_LEVEL(KEY_LEVEL), .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE), .KEY_EVENT(KEY_EVENT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] p, input logic [3:0] r);
    exp_t e;
    e.c = c; e.p = p; e.r = r;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  // every pulse must match the oldest outstanding expectation in cycle and value
  always @(negedge CLK) begin
    if (!RST && (KEY_PRESS != 0 || KEY_RELEASE != 0)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {KEY_PRESS, KEY_RELEASE}, 8'h00);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_press", KEY_PRESS, e.p);
        chk("pulse_release", KEY_RELEASE, e.r);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_level", KEY_LEVEL, 0);
    chk("rst_press", KEY_PRESS, 0);
    chk("rst_release", KEY_RELEASE, 0);
    chk("rst_event", KEY_EVENT, 0);
    RST = 0;
    repeat (3) @(negedge CLK);
    // clean press on channel 0
    n = cyc;
    PUSH[0] = 0;
    expect_pulse(n + 6, 4'b0001, 4'b0000);
    wait_until(n + 5);
    chk("press0_early_level", KEY_LEVEL, 4'b0000);
    chk("press0_early_event", KEY_EVENT, 4'b0000);
    wait_until(n + 6);
    chk("press0_level", KEY_LEVEL, 4'b0001);
    chk("press0_event", KEY_EVENT, 4'b0001);
    wait_until(n + 8);
    chk("press0_event_hold", KEY_EVENT, 4'b0001);
    // bounce on channel 1: low 3, high 1, then low held
    n = cyc;
    PUSH[1] = 0;
    wait_until(n + 3);
    PUSH[1] = 1;
    wait_until(n + 4);
    PUSH[1] = 0;
    expect_pulse(n + 10, 4'b0010, 4'b0000);
    wait_until(n + 9);
    chk("bounce1_early_level", KEY_LEVEL, 4'b0001);
    wait_until(n + 10);
    chk("bounce1_level", KEY_LEVEL, 4'b0011);
    wait_until(n + 12);
    // release channel 0 then clear its event
    n = cyc;
    PUSH[0] = 1;
    expect_pulse(n + 6, 4'b0000, 4'b0001);
    wait_until(n + 6);
    chk("release0_level", KEY_LEVEL, 4'b0010);
    chk("release0_event_kept", KEY_EVENT, 4'b0011);
    wait_until(n + 8);
    EVENT_CLR = 4'b0001;
    @(negedge CLK);
    EVENT_CLR = 4'b0000;
    chk("clear0_event", KEY_EVENT, 4'b0010);
    // set beats clear on channel 2
    n = cyc;
    PUSH[2] = 0;
    expect_pulse(n + 6, 4'b0100, 4'b0000);
    wait_until(n + 6);
    chk("setclr2_press_event", KEY_EVENT, 4'b0110);
    EVENT_CLR = 4'b0100;
    @(negedge CLK);
    EVENT_CLR = 4'b0000;
    chk("setclr2_event", KEY_EVENT, 4'b0110);
    wait_until(n + 10);
    // reset at counter 2 on channel 3; channels 1,2,3 held low through reset
    n = cyc;
    PUSH[3] = 0;
    wait_until(n + 4);
    RST = 1;
    @(negedge CLK);
    chk("midrst_level", KEY_LEVEL, 0);
    chk("midrst_press", KEY_PRESS, 0);
    chk("midrst_event", KEY_EVENT, 0);
    n = cyc;
    RST = 0;
    expect_pulse(n + 6, 4'b1110, 4'b0000);
    wait_until(n + 5);
    chk("postrst_early_level", KEY_LEVEL, 0);
    wait_until(n + 6);
    chk("postrst_level", KEY_LEVEL, 4'b1110);
    chk("postrst_event", KEY_EVENT, 4'b1110);
    wait_until(n + 8);
    // release everything, then press all four together
    n = cyc;
    PUSH = 4'hF;
    expect_pulse(n + 6, 4'b0000, 4'b1110);
    wait_until(n + 8);
    chk("allrel_level", KEY_LEVEL, 0);
    n = cyc;
    PUSH = 4'h0;
    expect_pulse(n + 6, 4'b1111, 4'b0000);
    wait_until(n + 6);
    chk("multi_level", KEY_LEVEL, 4'hF);
    chk("multi_event", KEY_EVENT, 4'hF);
    wait_until(n + 10);
    chk("pending_pulses", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
